// File: rtl/zb_tx_sequencer.sv
// Zigbee transmit sequencer: frames preamble, SFD and FIFO payload nibbles,
// and serialises every nibble LSB-first into the coder over a valid/ready handshake.
module zb_tx_sequencer #(
  parameter int         PREAMBLE_NIBBLES  = 8,
  parameter logic [7:0] SFD               = 8'hA7,
  parameter int         UNDERFLOW_TIMEOUT = 16
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inStart,
  input  logic [7:0] inFrameLen,
  input  logic       inFifoEmpty,
  input  logic [3:0] inFifoData,
  output logic       outFifoReadEnable,
  input  logic       inCoderReady,
  output logic       outCoderValid,
  output logic       outCoderData,
  output logic       outBusy,
  output logic       outDone,
  output logic       outUnderflow
);

  localparam int TW = $clog2(UNDERFLOW_TIMEOUT + 1);
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_NIBBLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(UNDERFLOW_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_FETCH, S_LOAD, S_SHIFT, S_DONE, S_ABORT
  } state_t;

  state_t        state, state_next;
  logic [1:0]    bit_cnt, bit_next;
  logic [7:0]    nib_cnt, nib_next;
  logic [TW-1:0] to_cnt, to_next;
  logic [3:0]    shift_reg, shift_next;
  logic [7:0]    frame_len, len_next;
  logic          read_en;
  logic          valid_next, data_next;
  logic          accept;

  assign accept = outCoderValid & inCoderReady;

  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    nib_next   = nib_cnt;
    to_next    = to_cnt;
    shift_next = shift_reg;
    len_next   = frame_len;
    read_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (inStart) begin
          len_next   = inFrameLen;
          bit_next   = 2'd0;
          nib_next   = 8'd0;
          to_next    = '0;
          shift_next = 4'd0;
          state_next = (PREAMBLE_NIBBLES == 0) ? S_SFD : S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (accept) begin
          bit_next = bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            nib_next = nib_cnt + 8'd1;
            if (nib_cnt == PRE_LAST) begin
              nib_next   = 8'd0;
              state_next = S_SFD;
            end
          end
        end
      end
      // The SFD bit index is {nib_cnt[0], bit_cnt}, walking bits 0..7.
      S_SFD: begin
        if (accept) begin
          bit_next = bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            nib_next = nib_cnt + 8'd1;
            if (nib_cnt[0]) begin
              nib_next   = 8'd0;
              state_next = (frame_len != 8'd0) ? S_FETCH : S_DONE;
            end
          end
        end
      end
      S_FETCH: begin
        if (!inFifoEmpty) begin
          read_en    = 1'b1;
          state_next = S_LOAD;
        end else begin
          to_next = to_cnt + 1'b1;
          if (to_cnt == TO_LAST) state_next = S_ABORT;
        end
      end
      S_LOAD: begin
        shift_next = inFifoData;
        to_next    = '0;
        bit_next   = 2'd0;
        state_next = S_SHIFT;
      end
      // Compare in 9 bits so a 255-nibble frame never wraps the counter.
      S_SHIFT: begin
        if (accept) begin
          shift_next = {1'b0, shift_reg[3:1]};
          bit_next   = bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            nib_next   = nib_cnt + 8'd1;
            state_next = (({1'b0, nib_cnt} + 9'd1) == {1'b0, frame_len}) ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ABORT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    valid_next = (state_next == S_PREAMBLE) || (state_next == S_SFD) || (state_next == S_SHIFT);
    data_next  = 1'b0;
    if (state_next == S_SFD)        data_next = SFD[{nib_next[0], bit_next}];
    else if (state_next == S_SHIFT) data_next = shift_next[0];
  end

  // Coder-facing outputs are registered from the next-state values so they
  // line up with the state they describe without any combinational path.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      state         <= S_IDLE;
      bit_cnt       <= 2'd0;
      nib_cnt       <= 8'd0;
      to_cnt        <= '0;
      shift_reg     <= 4'd0;
      frame_len     <= 8'd0;
      outCoderValid <= 1'b0;
      outCoderData  <= 1'b0;
      outBusy       <= 1'b0;
      outDone       <= 1'b0;
      outUnderflow  <= 1'b0;
    end else begin
      state         <= state_next;
      bit_cnt       <= bit_next;
      nib_cnt       <= nib_next;
      to_cnt        <= to_next;
      shift_reg     <= shift_next;
      frame_len     <= len_next;
      outCoderValid <= valid_next;
      outCoderData  <= data_next;
      outBusy       <= (state_next != S_IDLE);
      outDone       <= (state_next == S_DONE);
      outUnderflow  <= (state_next == S_ABORT);
    end
  end

  assign outFifoReadEnable = read_en;

endmodule

// File: doc/zb_tx_sequencer.md
# zb_tx_sequencer

Transmit-path controller for the Zigbee baseband. On a start command it frames one packet: 8 zero preamble nibbles, then the SFD 0xA7, then `inFrameLen` payload nibbles pulled from the inFIFO. Every nibble is serialised LSB-first into the coder over a valid/ready bit handshake. The block sits between the inFIFO read port and the coder serial input, replacing manual drive of the FIFO read-enable and coder empty lines.

## Interface
- `PREAMBLE_NIBBLES`, 8: number of 0x0 nibbles sent before the SFD.
- `SFD`, 8'hA7: start-of-frame delimiter. Low nibble is sent first.
- `UNDERFLOW_TIMEOUT`, 16: cycles FETCH may wait on an empty FIFO before the frame is aborted.
- `inClock` in 1: single clock, rising edge.
- `inReset` in 1: synchronous, active-high reset.
- `inStart` in 1: frame request. Sampled only in IDLE.
- `inFrameLen` in 8: payload length in nibbles. Latched on accepted start.
- `inFifoEmpty` in 1: inFIFO empty flag.
- `inFifoData` in 4: inFIFO read data. Valid the cycle after `outFifoReadEnable`.
- `outFifoReadEnable` out 1: one-cycle read pulse.
- `inCoderReady` in 1: coder accepts the presented bit this cycle.
- `outCoderValid` out 1: bit presented to the coder. The coder's empty input = `~outCoderValid`.
- `outCoderData` out 1: serial bit.
- `outBusy` out 1: high in every state except IDLE.
- `outDone` out 1: one-cycle pulse at frame completion.
- `outUnderflow` out 1: one-cycle pulse when a frame is aborted.

## Operation
- State register: IDLE, PREAMBLE, SFD, FETCH, LOAD, SHIFT, DONE, ABORT.
- Counters:
  - 2-bit bit counter.
  - 8-bit nibble counter.
  - timeout counter of width ceil(log2(UNDERFLOW_TIMEOUT+1)).
  - 4-bit shift register.
- IDLE, `inStart`=1: latch `inFrameLen`, clear counters, go to PREAMBLE.
- PREAMBLE:
  - `outCoderValid`=1, `outCoderData`=0.
  - After PREAMBLE_NIBBLES×4 accepted bits, go to SFD.
  - With PREAMBLE_NIBBLES=0, go directly to SFD.
- SFD:
  - Present `SFD[0]` … `SFD[7]` in that order, one per accepted bit.
  - After the 8th accepted bit: go to FETCH if the latched length is ≠0, else to DONE.
- FETCH:
  - `outCoderValid`=0.
  - If `~inFifoEmpty`: `outFifoReadEnable`=1 combinationally, go to LOAD.
  - Else increment the timeout counter. When it reaches UNDERFLOW_TIMEOUT, go to ABORT.
- LOAD: capture `inFifoData` into the shift register, clear the timeout counter, go to SHIFT.
- SHIFT:
  - `outCoderValid`=1, `outCoderData`=`shift[0]`.
  - On each accepted bit: shift right, increment the bit counter.
  - After the 4th accepted bit, increment the nibble counter. Go to DONE if nibble count = latched length, else to FETCH.
- DONE: `outDone`=1 for one cycle, then IDLE.
- ABORT: `outUnderflow`=1 for one cycle, then IDLE. A partially sent frame is not resumed.
- Transfer rule: a bit transfers when `outCoderValid` & `inCoderReady`. While `inCoderReady`=0, `outCoderData` and all state hold.
- `inStart` outside IDLE is ignored; it is not queued.
- `inFrameLen` changes after latch have no effect.

## Timing
- All outputs are registered except `outFifoReadEnable` (decoded from the state plus `inFifoEmpty`).
- Reset (`inReset`=1 at an edge): state IDLE, all counters 0, shift register 0. Every output is 0 from the next cycle.
- Reset mid-frame is honoured in any state. The coder sees valid drop the cycle after reset is sampled.
- Start latency: `inStart` high at edge N → `outCoderValid`=1 with the first preamble bit from cycle N+1.
- With `inCoderReady` held at 1:
  - Preamble and SFD run at one bit per cycle with no bubbles, including the PREAMBLE→SFD boundary.
  - Each payload nibble costs FETCH + LOAD (2 cycles with valid low) plus 4 bit cycles.
- Frame length in cycles with ready=1 and a non-empty FIFO: 4·PREAMBLE_NIBBLES + 8 + 6·inFrameLen + 1 (the DONE cycle).
- Empty FIFO in FETCH:
  - Each empty cycle increments the timeout counter.
  - The FIFO becoming non-empty before the timeout proceeds normally; the timeout is cleared in LOAD.
  - Timeout reached: ABORT is entered on the next edge and no read pulse is issued.
- `inFrameLen`=255: the nibble counter compares before it would wrap, so no overflow occurs.
- Simultaneous FIFO empty and ready low do not interact: FETCH ignores `inCoderReady`.

## Test plan
- Basic frame:
  - Stimulus: reset, FIFO preloaded {0x1, 0x4}, `inFrameLen`=2, ready=1, `inStart` pulse at cycle 0.
  - Required: bits 1–32 = 0; SFD bits 1,1,1,0,0,1,0,1; payload 1,0,0,0 then 0,0,1,0.
  - Required: exactly 2 read pulses (cycles 41 and 47); `outDone` at cycle 53; `outBusy` 1 for cycles 1–53.
- Zero length:
  - Stimulus: `inFrameLen`=0.
  - Required: 40 bits then `outDone`; no read pulse.
- Back-pressure:
  - Stimulus: `inCoderReady` toggling 1,0,0,1… during SHIFT of nibble 0x9.
  - Required: each bit is held while ready=0; the accepted sequence is 1,0,0,1; no bit is duplicated or dropped.
- Underflow:
  - Stimulus: FIFO empty after the SFD.
  - Required: 16 FETCH cycles, then `outUnderflow` pulse, IDLE, `outDone` never asserted.
  - Stimulus: a write arriving at FETCH cycle 10.
  - Required: normal completion.
- Start ignored while busy:
  - Stimulus: `inStart` pulses during PREAMBLE and SHIFT.
  - Required: no restart; the frame completes as in the basic-frame scenario.
- Reset mid-frame:
  - Stimulus: `inReset`=1 for 1 cycle during SHIFT.
  - Required: all outputs 0 next cycle; a new `inStart` then produces a full 40-bit header.
